rx_frame_checker: RTL
=====================

# rx_frame_checker

Parametrised, registered successor to the UART receiver's frame error checker. Sits between the Rx deframer and the APB register file: on each received-frame strobe it checks start, parity and one or two stop bits for a configurable data width. It registers the result with the data, detects line-break frames, and keeps sticky flags plus saturating per-error counters for software.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_WIDTH, 8, width of each error counter.
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- recieved_flag  in  1  one-cycle strobe; frame fields valid this cycle.
- raw_data  in  DATA_WIDTH  received data bits.
- start_bit  in  1  sampled start bit; expected 0.
- parity_bit  in  1  sampled parity bit; ignored when parity is off.
- stop_bits  in  2  [0] first stop, [1] second stop; expected 1.
- two_stop  in  1  1 means check stop_bits[1] as well.
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none.
- clear_status  in  1  one-cycle strobe; clears sticky flags and counters.
- check_done  out  1  one-cycle pulse; outputs below are valid.
- data_out  out  DATA_WIDTH  registered copy of raw_data.
- error_flag  out  3  {stop, start, parity}; valid with check_done.
- break_det  out  1  frame was a line break; valid with check_done.
- sticky_flags  out  3  OR-accumulated error_flag since the last clear.
- parity_err_cnt, start_err_cnt, stop_err_cnt  out  CNT_WIDTH each  saturating error counters.

## Operation
- All config inputs (two_stop, parity_type) are sampled only in the recieved_flag cycle.
- Parity uses raw_data[DATA_WIDTH-1:0].
  - Odd: expected = ~^raw_data.
  - Even: expected = ^raw_data.
  - parity error when parity_bit != expected.
  - Modes 00/11 force the parity error to 0.
- Start error: start_bit == 1.
- Stop error:
  - two_stop = 0: stop_bits[0] == 0.
  - two_stop = 1: stop_bits[0] == 0 or stop_bits[1] == 0.
- Break frame: raw_data == 0, start_bit == 0 and stop_bits[0] == 0.
- FSM, states LINE_OK and IN_BREAK:
  - LINE_OK, break frame: go to IN_BREAK, pulse break_det, report error_flag normally (stop error), count it.
  - IN_BREAK, further break frames: check_done pulses, break_det = 1, error_flag = 000, counters and sticky flags untouched.
  - IN_BREAK, any non-break frame: back to LINE_OK; that frame is checked normally.
- Counters increment by 1 for each reported error bit and saturate at all-ones; they never wrap.
- sticky_flags |= reported error_flag.

## Timing
- Latency: check_done, data_out, error_flag and break_det update one cycle after recieved_flag.
- The counters and sticky_flags update on that same edge.
- Back-to-back recieved_flag on consecutive cycles is supported; every frame produces one check_done.
- clear_status together with a reported frame: clear takes effect first, then the new frame's errors apply. Example: a parity error frame leaves parity_err_cnt = 1, sticky_flags = 001.
- With no recieved_flag, check_done = 0 and data_out, error_flag, break_det hold their values.
- Reset values: every output 0, FSM in LINE_OK. Reset beats all simultaneous strobes; a frame strobed in the reset cycle is dropped.

## Structure
- Shared package uart_rx_pkg holds:
  - parity_type encodings PARITY_NONE, PARITY_ODD, PARITY_EVEN, PARITY_NONE2;
  - error_flag bit indices ERR_PARITY = 0, ERR_START = 1, ERR_STOP = 2;
  - FSM state typedef.
- One sub-module, parity_calc: combinational, DATA_WIDTH-parametrised; takes data and parity_type, gives the expected parity bit and a parity-enabled flag. The Tx side reuses it.

## Test plan
- DATA_WIDTH = 8, raw_data = A5h, odd parity, parity_bit = 0, start = 0, stop = 01b -> next cycle check_done = 1, error_flag = 001, parity_err_cnt = 1.
- DATA_WIDTH = 7, raw_data = 7'h01, even parity, parity_bit = 1, two_stop = 1, stop_bits = 01b -> error_flag = 100, stop_err_cnt = 1.
- Three consecutive break frames, then 55h with a valid frame -> break_det = 1,1,1,0; stop_err_cnt = 1; fourth error_flag = 000; FSM back in LINE_OK.
- CNT_WIDTH = 4, 20 start-error frames back-to-back -> 20 check_done pulses, start_err_cnt holds at Fh.
- clear_status in the same cycle as a parity-error frame, with prior counts of 5 -> parity_err_cnt = 1, other counters 0, sticky_flags = 001.
- reset_n low mid-stream in a recieved_flag cycle -> all outputs 0 next cycle, no check_done for that frame.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART Rx definitions: parity mode encodings, error flag bit
// positions and the line-break tracking state type.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE  = 2'b00,
    PARITY_ODD   = 2'b01,
    PARITY_EVEN  = 2'b10,
    PARITY_NONE2 = 2'b11
  } parity_e;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;
  localparam int ERR_BITS   = 3;

  typedef enum logic {
    LINE_OK  = 1'b0,
    IN_BREAK = 1'b1
  } brk_state_e;

endpackage

// File: rtl/parity_calc.sv
// Expected parity bit for a data word. Shared with the Tx framer, so it
// stays purely combinational and knows nothing about frames.
module parity_calc import uart_rx_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            parity_type,
  output logic                  parity_exp,
  output logic                  parity_en
);

  // Decode the parity mode; both "none" encodings disable the check.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned -- that is what keeps combinational blocks latch-free.
    parity_exp = 1'b0;
    parity_en  = 1'b0;
    case (parity_type)
      PARITY_ODD: begin
        parity_exp = ~^data;
        parity_en  = 1'b1;
      end
      PARITY_EVEN: begin
        parity_exp = ^data;
        parity_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_frame_checker.sv
// Registered frame checker between the Rx deframer and the register file.
// Checks start/parity/stop per received frame, flags line breaks, and keeps
// sticky flags plus saturating per-error counters for software.
module rx_frame_checker import uart_rx_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  recieved_flag,
  input  logic [DATA_WIDTH-1:0] raw_data,
  input  logic                  start_bit,
  input  logic                  parity_bit,
  input  logic [1:0]            stop_bits,
  input  logic                  two_stop,
  input  logic [1:0]            parity_type,
  input  logic                  clear_status,
  output logic                  check_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            error_flag,
  output logic                  break_det,
  output logic [2:0]            sticky_flags,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  start_err_cnt,
  output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

  brk_state_e                state_q, state_d;
  logic                      parity_exp, parity_en;
  logic                      is_break;
  logic [ERR_BITS-1:0]       raw_err;
  logic [ERR_BITS-1:0]       rep_err;
  logic [CNT_WIDTH-1:0]      err_cnt_q [ERR_BITS];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 inc);
    if (inc && (v != '1)) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
    .data        (raw_data),
    .parity_type (parity_type),
    .parity_exp  (parity_exp),
    .parity_en   (parity_en)
  );

  // Frame classification from this cycle's fields.
  always_comb begin
    is_break            = (raw_data == '0) && !start_bit && !stop_bits[0];
    raw_err             = '0;
    raw_err[ERR_PARITY] = parity_en && (parity_bit != parity_exp);
    raw_err[ERR_START]  = start_bit;
    raw_err[ERR_STOP]   = !stop_bits[0] || (two_stop && !stop_bits[1]);
  end

  // Break-tracking state register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state_q <= LINE_OK;
    else          state_q <= state_d;
  end

  // Next state: each strobed frame decides whether the line is in a break.
  always_comb begin
    state_d = state_q;
    if (recieved_flag) state_d = is_break ? IN_BREAK : LINE_OK;
  end

  // Reported errors: repeat break frames are acknowledged but not counted.
  always_comb begin
    rep_err = raw_err;
    if (state_q == IN_BREAK && is_break) rep_err = '0;
  end

  // Per-frame result registers; they hold between frames.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      check_done <= 1'b0;
      data_out   <= '0;
      error_flag <= '0;
      break_det  <= 1'b0;
    end else begin
      check_done <= recieved_flag;
      if (recieved_flag) begin
        data_out   <= raw_data;
        error_flag <= rep_err;
        break_det  <= is_break;
      end
    end
  end

  // Sticky flags and counters: a clear applies before the new frame's errors.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sticky_flags <= '0;
      for (int i = 0; i < ERR_BITS; i++) err_cnt_q[i] <= '0;
    end else begin
      sticky_flags <= (clear_status ? 3'b000 : sticky_flags)
                    | (recieved_flag ? rep_err : 3'b000);
      for (int i = 0; i < ERR_BITS; i++)
        err_cnt_q[i] <= sat_inc(clear_status ? '0 : err_cnt_q[i],
                                recieved_flag && rep_err[i]);
    end
  end

  assign parity_err_cnt = err_cnt_q[ERR_PARITY];
  assign start_err_cnt  = err_cnt_q[ERR_START];
  assign stop_err_cnt   = err_cnt_q[ERR_STOP];

endmodule
